// File: rtl/mac_dot_seq_if.sv
// Command, operand-memory, PE and result signals of the dot-product sequencer.
// slave: the sequencer's view. master: the surrounding scheduler/memory/PE.
interface mac_dot_seq_if #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
);
   logic                     start;
   logic                     abort;
   logic        [LEN_W-1:0]  len;
   logic        [ADDR_W-1:0] base_a;
   logic        [ADDR_W-1:0] base_b;
   logic                     busy;
   logic                     mem_rd_en;
   logic        [ADDR_W-1:0] mem_a_addr;
   logic        [ADDR_W-1:0] mem_b_addr;
   logic signed [15:0]       mem_a_rdata;
   logic signed [15:0]       mem_b_rdata;
   logic signed [15:0]       pe_a;
   logic signed [15:0]       pe_b;
   logic                     pe_clr;
   logic signed [31:0]       pe_acc;
   logic signed [31:0]       res_data;
   logic                     res_valid;
   logic                     res_ready;

   modport slave (
      input  start, abort, len, base_a, base_b,
      input  mem_a_rdata, mem_b_rdata, pe_acc, res_ready,
      output busy, mem_rd_en, mem_a_addr, mem_b_addr,
      output pe_a, pe_b, pe_clr, res_data, res_valid
   );

   modport master (
      output start, abort, len, base_a, base_b,
      output mem_a_rdata, mem_b_rdata, pe_acc, res_ready,
      input  busy, mem_rd_en, mem_a_addr, mem_b_addr,
      input  pe_a, pe_b, pe_clr, res_data, res_valid
   );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: clears a MAC PE, streams LEN operand pairs from two
// SRAMs into it, waits out the pipeline and returns the accumulator value on
// a valid/ready result port.
module mac_dot_seq #(
   parameter int          ADDR_W  = 10,
   parameter int          LEN_W   = 10,
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned PE_LAT  = 1
) (
   input  logic          clk,
   input  logic          rst,
   mac_dot_seq_if.slave  bus
);

   // The registered PE operand stage adds one cycle on top of the memory and
   // PE latencies before the last product reaches pe_acc.
   localparam int unsigned DRAIN_CYC = MEM_LAT + PE_LAT + 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t             state;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   idx;
   logic [7:0]         drain_cnt;
   logic [MEM_LAT-1:0] vld_sr;

   // Control FSM: command accept, read issue, drain count, result handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         bus.busy       <= 1'b0;
         bus.mem_rd_en  <= 1'b0;
         bus.mem_a_addr <= '0;
         bus.mem_b_addr <= '0;
         bus.pe_clr     <= 1'b0;
         bus.res_valid  <= 1'b0;
         bus.res_data   <= '0;
         len_q          <= '0;
         idx            <= '0;
         drain_cnt      <= '0;
      end else if (state != IDLE && bus.abort) begin
         state         <= IDLE;
         bus.busy      <= 1'b0;
         bus.mem_rd_en <= 1'b0;
         bus.pe_clr    <= 1'b0;
         bus.res_valid <= 1'b0;
         idx           <= '0;
         drain_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  bus.busy       <= 1'b1;
                  len_q          <= bus.len;
                  bus.mem_a_addr <= bus.base_a;
                  bus.mem_b_addr <= bus.base_b;
                  idx            <= '0;
                  if (bus.len != '0) begin
                     bus.pe_clr <= 1'b1;
                     state      <= CLEAR;
                  end else begin
                     bus.res_data  <= '0;
                     bus.res_valid <= 1'b1;
                     state         <= DONE;
                  end
               end
            end
            CLEAR: begin
               bus.pe_clr    <= 1'b0;
               bus.mem_rd_en <= 1'b1;
               idx           <= LEN_W'(1);
               state         <= ISSUE;
            end
            ISSUE: begin
               if (idx == len_q) begin
                  bus.mem_rd_en <= 1'b0;
                  drain_cnt     <= '0;
                  state         <= DRAIN;
               end else begin
                  idx            <= idx + LEN_W'(1);
                  bus.mem_a_addr <= bus.mem_a_addr + ADDR_W'(1);
                  bus.mem_b_addr <= bus.mem_b_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == 8'(DRAIN_CYC - 1)) begin
                  bus.res_data  <= bus.pe_acc;
                  bus.res_valid <= 1'b1;
                  state         <= DONE;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-valid tracking and PE operand gating; zeros outside valid data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_sr   <= '0;
         bus.pe_a <= '0;
         bus.pe_b <= '0;
      end else if (state != IDLE && bus.abort) begin
         vld_sr   <= '0;
         bus.pe_a <= '0;
         bus.pe_b <= '0;
      end else begin
         vld_sr[0] <= bus.mem_rd_en;
         for (int unsigned i = 1; i < MEM_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
         bus.pe_a <= vld_sr[MEM_LAT-1] ? bus.mem_a_rdata : '0;
         bus.pe_b <= vld_sr[MEM_LAT-1] ? bus.mem_b_rdata : '0;
      end
   end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with behavioural SRAM and MAC PE models.
module tb_mac_dot_seq;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mac_dot_seq_if #(.ADDR_W(10), .LEN_W(10)) bus ();

   mac_dot_seq #(
      .ADDR_W (10),
      .LEN_W  (10),
      .MEM_LAT(1),
      .PE_LAT (1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic signed [15:0] mem_a [1024];
   logic signed [15:0] mem_b [1024];
   logic [9:0]         aq[$];
   logic [9:0]         bq[$];
   int                 nclr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle-latency SRAMs
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_a_rdata <= mem_a[bus.mem_a_addr];
         bus.mem_b_rdata <= mem_b[bus.mem_b_addr];
      end
   end

   // One-cycle-latency MAC PE
   always @(posedge clk) begin
      if (bus.pe_clr) bus.pe_acc <= '0;
      else            bus.pe_acc <= bus.pe_acc + bus.pe_a * bus.pe_b;
   end

   // Read address and clear-pulse log
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         aq.push_back(bus.mem_a_addr);
         bq.push_back(bus.mem_b_addr);
      end
      if (bus.pe_clr) nclr++;
   end

   task automatic clear_log();
      aq.delete();
      bq.delete();
      nclr = 0;
   endtask

   task automatic start_job(input logic [9:0] l, input logic [9:0] ba, input logic [9:0] bb);
      bus.len    = l;
      bus.base_a = ba;
      bus.base_b = bb;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.res_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.res_ready = 1'b0;
      bus.len = '0; bus.base_a = '0; bus.base_b = '0;
      #12;
      checks++;
      if ({bus.busy, bus.mem_rd_en, bus.pe_clr, bus.res_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b required 0000", {bus.busy, bus.mem_rd_en, bus.pe_clr, bus.res_valid});
      end
      checks++;
      if (bus.res_data !== 32'sd0 || bus.pe_a !== 16'sd0 || bus.pe_b !== 16'sd0) begin
         errors++;
         $display("FAIL reset_data: res_data=%0d pe_a=%0d pe_b=%0d required 0", bus.res_data, bus.pe_a, bus.pe_b);
      end
      checks++;
      if (bus.mem_a_addr !== 10'd0 || bus.mem_b_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset_addr: a=%0h b=%0h required 0", bus.mem_a_addr, bus.mem_b_addr);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      for (int i = 0; i < 4; i++) begin
         mem_a[i]      = 16'(i + 1);
         mem_b[16 + i] = 16'(i + 5);
      end
      clear_log();
      bus.res_ready = 1'b1;
      start_job(10'd4, 10'h000, 10'h010);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b required 1", bus.busy);
      end
      wait_valid(lat);
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL basic_latency: got %0d required 8", lat);
      end
      checks++;
      if (bus.res_data !== 32'sd70) begin
         errors++;
         $display("FAIL basic_result: got %0d required 70", bus.res_data);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_handshake: res_valid=%b busy=%b required 0 0", bus.res_valid, bus.busy);
      end
      checks++;
      if (nclr != 1 || aq.size() != 4) begin
         errors++;
         $display("FAIL basic_counts: clr=%0d reads=%0d required 1 4", nclr, aq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (aq[i] !== 10'(i) || bq[i] !== 10'(16 + i)) begin
               errors++;
               $display("FAIL basic_addr%0d: a=%0h b=%0h required %0h %0h", i, aq[i], bq[i], i, 16 + i);
            end
         end
      end
   endtask

   task automatic test_stall();
      int lat;
      mem_a[10'h40] = -16'sd32768; mem_a[10'h41] = 16'sd32767; mem_a[10'h42] = -16'sd7;
      mem_b[10'h50] = 16'sd1;      mem_b[10'h51] = 16'sd1;     mem_b[10'h52] = -16'sd6;
      clear_log();
      bus.res_ready = 1'b0;
      start_job(10'd3, 10'h040, 10'h050);
      wait_valid(lat);
      checks++;
      if (lat != 7) begin
         errors++;
         $display("FAIL stall_latency: got %0d required 7", lat);
      end
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            bus.len = 10'd0; bus.base_a = '0; bus.base_b = '0;
            bus.start = 1'b1;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         checks++;
         if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1 || bus.res_data !== 32'sd41) begin
            errors++;
            $display("FAIL stall_hold%0d: valid=%b busy=%b data=%0d required 1 1 41", c, bus.res_valid, bus.busy, bus.res_data);
         end
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      checks++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_handshake: valid=%b busy=%b required 0 0", bus.res_valid, bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || aq.size() != 3) begin
         errors++;
         $display("FAIL stall_start_ignored: busy=%b valid=%b reads=%0d required 0 0 3", bus.busy, bus.res_valid, aq.size());
      end
   endtask

   task automatic test_len0();
      int lat;
      clear_log();
      bus.res_ready = 1'b1;
      start_job(10'd0, 10'h123, 10'h234);
      wait_valid(lat);
      checks++;
      if (lat != 0) begin
         errors++;
         $display("FAIL len0_latency: got %0d extra cycles required 0", lat);
      end
      checks++;
      if (bus.res_data !== 32'sd0) begin
         errors++;
         $display("FAIL len0_result: got %0d required 0", bus.res_data);
      end
      @(posedge clk); #1;
      checks++;
      if (aq.size() != 0 || nclr != 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL len0_side_effects: reads=%0d clr=%0d busy=%b required 0 0 0", aq.size(), nclr, bus.busy);
      end
   endtask

   task automatic test_wrap();
      int lat;
      logic [9:0] ea [4];
      ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000; ea[3] = 10'h001;
      mem_a[10'h3FE] = 16'sd10; mem_a[10'h3FF] = -16'sd3; mem_a[0] = 16'sd1; mem_a[1] = 16'sd2;
      mem_b[10'h100] = 16'sd2;  mem_b[10'h101] = 16'sd4;  mem_b[10'h102] = 16'sd5; mem_b[10'h103] = -16'sd1;
      clear_log();
      bus.res_ready = 1'b1;
      start_job(10'd4, 10'h3FE, 10'h100);
      wait_valid(lat);
      checks++;
      if (bus.res_data !== 32'sd11) begin
         errors++;
         $display("FAIL wrap_result: got %0d required 11", bus.res_data);
      end
      @(posedge clk); #1;
      checks++;
      if (aq.size() != 4) begin
         errors++;
         $display("FAIL wrap_reads: got %0d required 4", aq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (aq[i] !== ea[i]) begin
               errors++;
               $display("FAIL wrap_addr%0d: got %0h required %0h", i, aq[i], ea[i]);
            end
         end
      end
   endtask

   task automatic test_abort();
      int  lat;
      logic seen;
      for (int i = 0; i < 8; i++) begin
         mem_a[10'h20 + i] = 16'sd9;
         mem_b[10'h30 + i] = 16'sd7;
      end
      mem_a[10'h60] = 16'sd2; mem_a[10'h61] = 16'sd3;
      mem_b[10'h70] = 16'sd4; mem_b[10'h71] = 16'sd5;
      clear_log();
      bus.res_ready = 1'b1;
      start_job(10'd8, 10'h020, 10'h030);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.pe_clr !== 1'b0) begin
         errors++;
         $display("FAIL abort_flags: busy=%b rd=%b clr=%b required 0 0 0", bus.busy, bus.mem_rd_en, bus.pe_clr);
      end
      checks++;
      if (bus.pe_a !== 16'sd0 || bus.pe_b !== 16'sd0) begin
         errors++;
         $display("FAIL abort_operands: pe_a=%0d pe_b=%0d required 0 0", bus.pe_a, bus.pe_b);
      end
      checks++;
      if (aq.size() != 2) begin
         errors++;
         $display("FAIL abort_reads: got %0d required 2", aq.size());
      end
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_result: got activity=%b required 0", seen);
      end
      start_job(10'd2, 10'h060, 10'h070);
      wait_valid(lat);
      checks++;
      if (lat != 6 || bus.res_data !== 32'sd23) begin
         errors++;
         $display("FAIL abort_next_job: lat=%0d data=%0d required 6 23", lat, bus.res_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int  lat;
      logic seen;
      for (int i = 0; i < 5; i++) begin
         mem_a[10'h80 + i] = 16'(i + 1);
         mem_b[10'h90 + i] = 16'sd1;
      end
      clear_log();
      bus.res_ready = 1'b1;
      start_job(10'd5, 10'h080, 10'h090);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.mem_rd_en, bus.pe_clr, bus.res_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_flags: got %b required 0000", {bus.busy, bus.mem_rd_en, bus.pe_clr, bus.res_valid});
      end
      checks++;
      if (bus.pe_a !== 16'sd0 || bus.pe_b !== 16'sd0 || bus.res_data !== 32'sd0 || bus.mem_a_addr !== 10'd0) begin
         errors++;
         $display("FAIL rstmid_data: pe_a=%0d pe_b=%0d data=%0d addr=%0h required 0", bus.pe_a, bus.pe_b, bus.res_data, bus.mem_a_addr);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_no_result: got activity=%b required 0", seen);
      end
      start_job(10'd5, 10'h080, 10'h090);
      wait_valid(lat);
      checks++;
      if (lat != 9 || bus.res_data !== 32'sd15) begin
         errors++;
         $display("FAIL rstmid_next_job: lat=%0d data=%0d required 9 15", lat, bus.res_data);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      test_reset();
      test_basic();
      test_stall();
      test_len0();
      test_wrap();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
